bmp_gray_binarize_core: RTL and testbench
=========================================

// Module: bmp_gray_binarize_core
// PURPOSE
//  Converts a 24-bit BGR BMP image, held in an external byte-wide sync ROM, into a
//  black/white BMP stored in an internal dual-port byte RAM. Phase 1 copies the header
//  and writes per-pixel gray values. Phase 2 thresholds every pixel to 0x00 or 0xFF.
//  It sits between the image ROM and the file-dump logic, which reads the RAM after done.
// PARAMETERS
//  BYTE_WIDTH     8    data width of ROM/RAM words
//  ADDR_WIDTH     20   byte address width (2**ADDR_WIDTH >= BMP_TOTAL_SIZE)
//  BMP_TOTAL_SIZE 786486  total file bytes, header included
//  HEADER_SIZE    54   header bytes, copied unchanged
//  THRESHOLD      128  gray >= THRESHOLD -> 0xFF, else 0x00
// PORTS
//  clk        in   1           rising-edge clock
//  rst        in   1           synchronous, active-high reset
//  in_valid   in   1           start request (level); sampled in IDLE
//  rom_ren    out  1           ROM read enable
//  rom_addr   out  ADDR_WIDTH  ROM byte address
//  rom_out    in   BYTE_WIDTH  ROM data, valid 1 cycle after rom_ren
//  dump_addr  in   ADDR_WIDTH  RAM read-back address (port B, only while done=1)
//  dump_data  out  BYTE_WIDTH  RAM[dump_addr], registered, 1-cycle latency
//  gray_done  out  1           phase 1 complete (sticky)
//  done       out  1           phase 2 complete (sticky)
// BEHAVIOUR
//  - Reset: rom_ren=0, rom_addr=0, gray_done=0, done=0, dump_data=0, FSM->IDLE.
//    RAM contents are not cleared. Reset mid-run aborts at once; partial RAM data stays.
//  - RAM: 2 ports. Each port has sync write and sync read with 1-cycle latency.
//    Same-address same-cycle writes: port B wins (never occurs internally).
//  - FSM: IDLE -> HDR -> PIX_RD -> PIX_WR -> (PIX_RD | TAIL | BIN_RD)
//    BIN_RD -> BIN_WR -> (BIN_RD | FIN); FIN holds until rst.
//  - IDLE: leave when in_valid=1 is sampled. in_valid is ignored in all other states.
//  - HDR: for a in 0..HEADER_SIZE-1:
//    - cycle 1: read ROM[a]; cycle 2: write RAM[a] via port A. 2 cycles per byte.
//  - PIX: pixel base p = HEADER_SIZE + 3k, bytes ordered B,G,R. 6 cycles per pixel.
//    - 3 consecutive ROM reads (p, p+1, p+2), data captured on the following cycles.
//    - gray = (29*B + 150*G + 77*R) >> 8, computed at 18-bit width; result is 0..255.
//    - Write gray to RAM[p], RAM[p+1], RAM[p+2] over 3 consecutive port-A cycles.
//  - Pixel count P = (BMP_TOTAL_SIZE-HEADER_SIZE)/3.
//  - TAIL: the (BMP_TOTAL_SIZE-HEADER_SIZE)%3 leftover bytes are copied as in HDR.
//  - gray_done rises the cycle after the last phase-1 write. Phase 2 starts next cycle.
//  - BIN (port B): for each pixel, 5 cycles per pixel:
//    - read RAM[p], wait 1 cycle for data;
//    - bin = (gray >= THRESHOLD) ? 8'hFF : 8'h00;
//    - write bin to p, p+1, p+2 over 3 cycles.
//    - Header and tail bytes are untouched.
//  - done rises the cycle after the last BIN write and stays 1 until rst.
//    Port B is then handed to dump_addr/dump_data.
//  - rom_ren is 1 only on ROM read cycles. rom_addr holds its value when rom_ren=0.
//  - Total latency from in_valid to done: 2*HEADER_SIZE + 6*P + 2*tail + 5*P + 2 cycles.
// TESTING
//  - Use BMP_TOTAL_SIZE=66, HEADER_SIZE=54 (4 pixels) for all directed cases below.
//  - Header 0x00..0x35 at ROM[0..53] -> after done, RAM[0..53] matches ROM bit-exact.
//  - Pixels BGR:
//    - (255,255,255) -> gray 255, bin FF FF FF
//    - (0,0,255)     -> gray 76,  bin 00 00 00
//    - (128,128,128) -> gray 128, bin FF FF FF
//    - (127,127,127) -> gray 127, bin 00 00 00
//  - Check RAM at gray_done for gray values (e.g. bytes 54..56 = 4C 4C 4C for the
//    red pixel, if placed first). Check done latency = 2*54+24+20+2 = 154 cycles
//    after in_valid is sampled.
//  - Assert rst 20 cycles into phase 1 -> all outputs reset next cycle.
//    Re-run with in_valid -> same final image.
//  - Keep in_valid=0 for 100 cycles -> rom_ren stays 0, gray_done and done stay 0.
//  - After done, sweep dump_addr 0..65 -> dump_data returns each byte 1 cycle later.
//    done stays 1 and in_valid toggling has no effect.

Source files
------------

// File: rtl/bmp_gray_binarize_core_if.sv
// Start/status, image-ROM read and RAM dump-port signals of bmp_gray_binarize_core.
interface bmp_gray_binarize_core_if #(
  parameter int unsigned BYTE_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 20
);
  logic                  in_valid;
  logic                  rom_ren;
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic [BYTE_WIDTH-1:0] rom_out;
  logic [ADDR_WIDTH-1:0] dump_addr;
  logic [BYTE_WIDTH-1:0] dump_data;
  logic                  gray_done;
  logic                  done;

  modport master (
    output in_valid, rom_out, dump_addr,
    input  rom_ren, rom_addr, dump_data, gray_done, done
  );

  modport slave (
    input  in_valid, rom_out, dump_addr,
    output rom_ren, rom_addr, dump_data, gray_done, done
  );
endinterface

// File: rtl/bmp_gray_binarize_core.sv
// Copies a 24-bit BGR BMP from ROM into a dual-port RAM as gray pixels (phase 1),
// then thresholds each pixel to black/white in place (phase 2) for the dump logic.
module bmp_gray_binarize_core #(
  parameter int unsigned BYTE_WIDTH     = 8,
  parameter int unsigned ADDR_WIDTH     = 20,
  parameter int unsigned BMP_TOTAL_SIZE = 786486,
  parameter int unsigned HEADER_SIZE    = 54,
  parameter int unsigned THRESHOLD      = 128
) (
  input  logic                    clk,
  input  logic                    rst,
  bmp_gray_binarize_core_if.slave bus
);

  localparam int unsigned NUM_PIX   = (BMP_TOTAL_SIZE - HEADER_SIZE) / 3;
  localparam int unsigned TAIL_SIZE = (BMP_TOTAL_SIZE - HEADER_SIZE) % 3;
  localparam int unsigned PIX_END   = HEADER_SIZE + 3 * NUM_PIX;
  localparam int unsigned DEPTH     = 2 ** ADDR_WIDTH;
  localparam int unsigned SUM_WIDTH = 18;
  localparam logic [1:0]  STEP_SETTLE = 2'd3;

  typedef enum logic [2:0] {
    IDLE, HDR, PIX_RD, PIX_WR, TAIL, BIN_RD, BIN_WR, FIN
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            step_q, step_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;

  logic [BYTE_WIDTH-1:0] b_q, g_q, gray_q, bin_q, b_rdata;
  logic [SUM_WIDTH-1:0]  gray_sum_c;
  logic [BYTE_WIDTH-1:0] gray_c;

  logic                  rom_ren_d, gray_done_d, done_d, p1_end;
  logic [ADDR_WIDTH-1:0] rom_addr_d;

  logic                  a_we, b_we;
  logic [ADDR_WIDTH-1:0] a_addr, b_addr;
  logic [BYTE_WIDTH-1:0] a_wdata, b_wdata;

  logic [BYTE_WIDTH-1:0] mem [DEPTH];

  // Luma from captured B, G and the R byte arriving this cycle
  always_comb begin
    gray_sum_c = SUM_WIDTH'(29)  * SUM_WIDTH'(b_q)
               + SUM_WIDTH'(150) * SUM_WIDTH'(g_q)
               + SUM_WIDTH'(77)  * SUM_WIDTH'(bus.rom_out);
    gray_c     = BYTE_WIDTH'(gray_sum_c >> 8);
  end

  // Next state, RAM port controls and next values of the registered outputs
  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    base_d      = base_q;
    gray_done_d = bus.gray_done;
    done_d      = bus.done;
    p1_end      = 1'b0;
    a_we        = 1'b0;
    a_addr      = base_q;
    a_wdata     = bus.rom_out;
    b_we        = 1'b0;
    b_addr      = base_q;
    b_wdata     = bin_q;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d = HDR;
          step_d  = 2'd0;
          base_d  = '0;
        end
      end
      HDR, TAIL: begin
        if (step_q == 2'd0) begin
          step_d = 2'd1;
        end else begin
          a_we   = 1'b1;
          step_d = 2'd0;
          base_d = base_q + ADDR_WIDTH'(1);
          if (state_q == HDR && base_q == ADDR_WIDTH'(HEADER_SIZE - 1)) begin
            if (NUM_PIX != 0)        state_d = PIX_RD;
            else if (TAIL_SIZE != 0) state_d = TAIL;
            else                     p1_end  = 1'b1;
          end else if (state_q == TAIL && base_q == ADDR_WIDTH'(BMP_TOTAL_SIZE - 1)) begin
            p1_end = 1'b1;
          end
        end
      end
      PIX_RD: begin
        if (step_q == 2'd2) begin
          state_d = PIX_WR;
          step_d  = 2'd0;
        end else begin
          step_d = step_q + 2'd1;
        end
      end
      PIX_WR: begin
        a_we    = 1'b1;
        a_addr  = base_q + ADDR_WIDTH'(step_q);
        a_wdata = (step_q == 2'd0) ? gray_c : gray_q;
        if (step_q == 2'd2) begin
          step_d = 2'd0;
          base_d = base_q + ADDR_WIDTH'(3);
          if (base_q == ADDR_WIDTH'(PIX_END - 3)) begin
            if (TAIL_SIZE != 0) state_d = TAIL;
            else                p1_end  = 1'b1;
          end else begin
            state_d = PIX_RD;
          end
        end else begin
          step_d = step_q + 2'd1;
        end
      end
      BIN_RD: begin
        // Settle step: the single cycle between gray_done and the first BIN read
        if (step_q == STEP_SETTLE) begin
          step_d = 2'd0;
          base_d = ADDR_WIDTH'(HEADER_SIZE);
          if (NUM_PIX == 0) begin
            state_d = FIN;
            done_d  = 1'b1;
          end
        end else if (step_q == 2'd0) begin
          step_d = 2'd1;
        end else begin
          state_d = BIN_WR;
          step_d  = 2'd0;
        end
      end
      BIN_WR: begin
        b_we   = 1'b1;
        b_addr = base_q + ADDR_WIDTH'(step_q);
        if (step_q == 2'd2) begin
          step_d = 2'd0;
          base_d = base_q + ADDR_WIDTH'(3);
          if (base_q == ADDR_WIDTH'(PIX_END - 3)) begin
            state_d = FIN;
            done_d  = 1'b1;
          end else begin
            state_d = BIN_RD;
          end
        end else begin
          step_d = step_q + 2'd1;
        end
      end
      FIN: begin
        b_addr = bus.dump_addr;
      end
      default: state_d = IDLE;
    endcase

    if (p1_end) begin
      state_d     = BIN_RD;
      step_d      = STEP_SETTLE;
      gray_done_d = 1'b1;
    end

    rom_ren_d  = (state_d == PIX_RD) ||
                 ((state_d == HDR || state_d == TAIL) && step_d == 2'd0);
    rom_addr_d = rom_ren_d ? base_d + ADDR_WIDTH'(step_d) : bus.rom_addr;
  end

  // State, outputs and pixel datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      step_q        <= 2'd0;
      base_q        <= '0;
      bus.rom_ren   <= 1'b0;
      bus.rom_addr  <= '0;
      bus.gray_done <= 1'b0;
      bus.done      <= 1'b0;
      bus.dump_data <= '0;
      b_q           <= '0;
      g_q           <= '0;
      gray_q        <= '0;
      bin_q         <= '0;
    end else begin
      state_q       <= state_d;
      step_q        <= step_d;
      base_q        <= base_d;
      bus.rom_ren   <= rom_ren_d;
      bus.rom_addr  <= rom_addr_d;
      bus.gray_done <= gray_done_d;
      bus.done      <= done_d;
      if (state_q == PIX_RD && step_q == 2'd1) b_q <= bus.rom_out;
      if (state_q == PIX_RD && step_q == 2'd2) g_q <= bus.rom_out;
      if (state_q == PIX_WR && step_q == 2'd0) gray_q <= gray_c;
      if (state_q == BIN_RD && step_q == 2'd1)
        bin_q <= (b_rdata >= BYTE_WIDTH'(THRESHOLD)) ? '1 : '0;
      if (state_q == FIN) bus.dump_data <= mem[b_addr];
    end
  end

  // Dual-port byte RAM, contents survive reset; port B is written last so it wins
  always_ff @(posedge clk) begin
    if (a_we) mem[a_addr] <= a_wdata;
    if (b_we) mem[b_addr] <= b_wdata;
    b_rdata <= mem[b_addr];
  end

endmodule

// File: tb/tb_bmp_gray_binarize_core.sv
// Directed bench for bmp_gray_binarize_core on a 66-byte image (54-byte header, 4 pixels).
module tb_bmp_gray_binarize_core;

  localparam int unsigned BW            = 8;
  localparam int unsigned AW            = 7;
  localparam int unsigned TOTAL         = 66;
  localparam int unsigned HDR           = 54;
  localparam int unsigned GRAY_DONE_LAT = 133;
  localparam int unsigned DONE_LAT      = 154;
  localparam int unsigned MAX_WAIT      = 400;

  logic clk = 1'b0;
  logic rst;
  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  logic [BW-1:0] rom      [2**AW];
  logic [BW-1:0] exp_gray [TOTAL];
  logic [BW-1:0] exp_img  [TOTAL];

  // Pixels in B,G,R order: red, white, mid-gray 128, mid-gray 127
  logic [BW-1:0] pix_bytes [12] = '{8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                                    8'h80, 8'h80, 8'h80, 8'h7F, 8'h7F, 8'h7F};
  logic [BW-1:0] pix_gray  [4]  = '{8'h4C, 8'hFF, 8'h80, 8'h7F};
  logic [BW-1:0] pix_bin   [4]  = '{8'h00, 8'hFF, 8'hFF, 8'h00};

  bmp_gray_binarize_core_if #(.BYTE_WIDTH(BW), .ADDR_WIDTH(AW)) bus ();

  bmp_gray_binarize_core #(
    .BYTE_WIDTH(BW), .ADDR_WIDTH(AW), .BMP_TOTAL_SIZE(TOTAL),
    .HEADER_SIZE(HDR), .THRESHOLD(128)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Synchronous image ROM, one-cycle read latency
  always @(posedge clk) begin
    if (bus.rom_ren) bus.rom_out <= rom[bus.rom_addr];
  end

  task automatic load_image();
    for (int i = 0; i < 2**AW; i++) rom[i] = '0;
    for (int i = 0; i < HDR; i++) begin
      rom[i]      = BW'(i);
      exp_gray[i] = BW'(i);
      exp_img[i]  = BW'(i);
    end
    for (int i = 0; i < 12; i++) begin
      rom[HDR + i]      = pix_bytes[i];
      exp_gray[HDR + i] = pix_gray[i / 3];
      exp_img[HDR + i]  = pix_bin[i / 3];
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (bus.rom_ren !== 1'b0) begin
      miscompares++; $display("FAIL reset_rom_ren: got %b want 0", bus.rom_ren);
    end
    vectors++;
    if (bus.rom_addr !== '0) begin
      miscompares++; $display("FAIL reset_rom_addr: got %0d want 0", bus.rom_addr);
    end
    vectors++;
    if (bus.gray_done !== 1'b0) begin
      miscompares++; $display("FAIL reset_gray_done: got %b want 0", bus.gray_done);
    end
    vectors++;
    if (bus.done !== 1'b0) begin
      miscompares++; $display("FAIL reset_done: got %b want 0", bus.done);
    end
    vectors++;
    if (bus.dump_data !== '0) begin
      miscompares++; $display("FAIL reset_dump_data: got %h want 00", bus.dump_data);
    end
    rst = 1'b0;
  endtask

  task automatic test_idle_hold();
    bus.in_valid = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      vectors++;
      if ({bus.rom_ren, bus.gray_done, bus.done} !== 3'b000) begin
        miscompares++;
        $display("FAIL idle_hold: cycle %0d ren/gray_done/done=%b want 000",
                 c, {bus.rom_ren, bus.gray_done, bus.done});
      end
    end
  endtask

  task automatic test_full_run();
    int unsigned lat    = 0;
    int unsigned gd_lat = 0;
    int unsigned rd_idx = 0;
    logic [AW-1:0] prev_addr;
    bus.in_valid = 1'b1;
    prev_addr    = bus.rom_addr;
    while (bus.done !== 1'b1 && lat < MAX_WAIT) begin
      @(negedge clk);
      lat++;
      bus.in_valid = (lat >= 30 && lat < 40);
      vectors++;
      if (bus.rom_ren === 1'b1) begin
        if (bus.rom_addr !== AW'(rd_idx)) begin
          miscompares++;
          $display("FAIL rom_read_order: read %0d addr %0d want %0d", rd_idx, bus.rom_addr, rd_idx);
        end
        rd_idx++;
      end else if (bus.rom_addr !== prev_addr) begin
        miscompares++;
        $display("FAIL rom_addr_hold: cycle %0d addr %0d want %0d", lat, bus.rom_addr, prev_addr);
      end
      prev_addr = bus.rom_addr;
      if (bus.gray_done === 1'b1 && gd_lat == 0) begin
        gd_lat = lat;
        for (int i = HDR; i < TOTAL; i++) begin
          vectors++;
          if (dut.mem[AW'(i)] !== exp_gray[i]) begin
            miscompares++;
            $display("FAIL gray_ram: byte %0d got %h want %h", i, dut.mem[AW'(i)], exp_gray[i]);
          end
        end
      end
    end
    bus.in_valid = 1'b0;
    vectors++;
    if (gd_lat != GRAY_DONE_LAT) begin
      miscompares++; $display("FAIL gray_done_latency: got %0d want %0d", gd_lat, GRAY_DONE_LAT);
    end
    vectors++;
    if (lat != DONE_LAT || bus.done !== 1'b1) begin
      miscompares++; $display("FAIL done_latency: got %0d (done=%b) want %0d", lat, bus.done, DONE_LAT);
    end
    vectors++;
    if (rd_idx != TOTAL) begin
      miscompares++; $display("FAIL rom_read_count: got %0d want %0d", rd_idx, TOTAL);
    end
  endtask

  task automatic test_dump();
    for (int i = 0; i < TOTAL; i++) begin
      bus.dump_addr = AW'(i);
      bus.in_valid  = i[0];
      @(negedge clk);
      vectors++;
      if (bus.dump_data !== exp_img[i]) begin
        miscompares++; $display("FAIL dump_data: addr %0d got %h want %h", i, bus.dump_data, exp_img[i]);
      end
      vectors++;
      if (bus.done !== 1'b1 || bus.rom_ren !== 1'b0) begin
        miscompares++; $display("FAIL done_sticky: addr %0d done=%b ren=%b want 1/0", i, bus.done, bus.rom_ren);
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_abort_rerun();
    int unsigned lat = 0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if ({bus.rom_ren, bus.gray_done, bus.done} !== 3'b000) begin
      miscompares++;
      $display("FAIL abort_flags: ren/gray_done/done=%b want 000", {bus.rom_ren, bus.gray_done, bus.done});
    end
    vectors++;
    if (bus.rom_addr !== '0 || bus.dump_data !== '0) begin
      miscompares++;
      $display("FAIL abort_regs: rom_addr=%0d dump_data=%h want 0/00", bus.rom_addr, bus.dump_data);
    end
    rst = 1'b0;
    bus.in_valid = 1'b1;
    while (bus.done !== 1'b1 && lat < MAX_WAIT) begin
      @(negedge clk);
      lat++;
      bus.in_valid = 1'b0;
    end
    vectors++;
    if (lat != DONE_LAT) begin
      miscompares++; $display("FAIL rerun_latency: got %0d want %0d", lat, DONE_LAT);
    end
    for (int i = 0; i < TOTAL; i++) begin
      bus.dump_addr = AW'(i);
      @(negedge clk);
      vectors++;
      if (bus.dump_data !== exp_img[i]) begin
        miscompares++; $display("FAIL rerun_image: addr %0d got %h want %h", i, bus.dump_data, exp_img[i]);
      end
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.dump_addr = '0;
    load_image();
    test_reset();
    test_idle_hold();
    test_full_run();
    test_dump();
    test_abort_rerun();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
